nf10_axis_downsizer: RTL and testbench

//  Width down-converter for the AXI4-Stream datapath. Splits each 256-bit slave beat into up to four
//  64-bit master beats, lane 0 (bits [63:0]) first. Sits on the egress side of the 256-bit core,

---
 rtl/nf10_axis_downsizer_pkg.sv | 33 +++
 rtl/nf10_axis_downsizer_if.sv | 31 +++
 rtl/nf10_axis_last_lane_finder.sv | 31 +++
 rtl/nf10_axis_downsizer.sv | 174 +++++++++++++++++
 tb/tb_nf10_axis_downsizer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nf10_axis_downsizer_pkg.sv
// nf10_axis_pkg
//   Shared constants and types for the 256->64 AXI4-Stream width down-converter.
//   Widths here are the default build; the modules re-derive lane counts from
//   their own parameters so the package values only seed defaults.
//   tuser layout (valid on the first beat of a packet):
//     [15:0]  packet length in bytes
//     [23:16] source port
//     [31:24] destination port
package nf10_axis_pkg;

    localparam int S_DATA_W = 256;
    localparam int M_DATA_W = 64;
    localparam int TUSER_W  = 128;

    localparam int RATIO    = S_DATA_W / M_DATA_W;
    localparam int LANE_W   = $clog2(RATIO);
    localparam int STRB_M   = M_DATA_W / 8;
    localparam int STRB_S   = S_DATA_W / 8;

    localparam int TUSER_LEN_LO = 0;
    localparam int TUSER_LEN_HI = 15;
    localparam int TUSER_SRC_LO = 16;
    localparam int TUSER_SRC_HI = 23;
    localparam int TUSER_DST_LO = 24;
    localparam int TUSER_DST_HI = 31;

    // EMPTY: nothing held. SEND: one slave beat held, emitting lane cnt.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

endpackage

// File: rtl/nf10_axis_downsizer_if.sv
// nf10_axis_downsizer_if
//   One AXI4-Stream link. Instantiated once per side with the width of that side.
//   Signals: tdata, tstrb (one bit per byte), tuser, tvalid, tready, tlast.
//   Modports:
//     master - drives tdata/tstrb/tuser/tvalid/tlast, receives tready
//     slave  - receives tdata/tstrb/tuser/tvalid/tlast, drives tready
interface nf10_axis_downsizer_if
    import nf10_axis_pkg::*;
#(
    parameter int DATA_W = M_DATA_W,
    parameter int USER_W = TUSER_W
);

    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (
        output tdata, tstrb, tuser, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tuser, tvalid, tlast,
        output tready
    );

endinterface

// File: rtl/nf10_axis_last_lane_finder.sv
// nf10_axis_last_lane_finder
//   Combinational priority encoder: returns the index of the highest master
//   lane whose strobe group has any bit set. An all-zero strobe maps to lane 0
//   so a strobe-less last beat still produces exactly one master beat.
//   Ports:
//     strb      in  STRB_W  slave byte strobes
//     last_lane out OUT_W   highest lane with a nonzero strobe group
module nf10_axis_last_lane_finder
    import nf10_axis_pkg::*;
#(
    parameter int STRB_W  = STRB_S,
    parameter int GROUP_W = STRB_M,
    parameter int OUT_W   = LANE_W
) (
    input  logic [STRB_W-1:0] strb,
    output logic [OUT_W-1:0]  last_lane
);

    localparam int N_GROUPS = STRB_W / GROUP_W;

    // Ascending scan: the last matching group wins, giving the highest lane.
    always_comb begin
        last_lane = '0;
        for (int i = 0; i < N_GROUPS; i++) begin
            if (|strb[i*GROUP_W +: GROUP_W]) begin
                last_lane = i[OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/nf10_axis_downsizer.sv
// nf10_axis_downsizer
//   AXI4-Stream width down-converter. Each slave beat is held and replayed as
//   up to C_S/C_M master beats, lane 0 (lowest bits) first. Non-last slave
//   beats always emit every lane; a last beat stops at the highest lane with a
//   nonzero strobe group. A new slave beat is accepted in the same cycle the
//   final lane of the held beat is taken, so the master side never bubbles.
//   Ports:
//     axi_aclk    in  clock, rising edge
//     axi_resetn  in  synchronous active-low reset
//     s_axis      slave modport, C_S_AXIS_DATA_WIDTH wide
//     m_axis      master modport, C_M_AXIS_DATA_WIDTH wide
//   Build option:
//     NF10_DOWNSIZER_TUSER_HOLD_EN defined   -> every master beat of a packet
//                                               carries the packet's tuser
//     NF10_DOWNSIZER_TUSER_HOLD_EN undefined -> only the first master beat of a
//                                               packet carries tuser, others 0
module nf10_axis_downsizer
    import nf10_axis_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = S_DATA_W,
    parameter int C_M_AXIS_DATA_WIDTH  = M_DATA_W,
    parameter int C_S_AXIS_TUSER_WIDTH = TUSER_W,
    parameter int C_M_AXIS_TUSER_WIDTH = TUSER_W
) (
    input  logic                  axi_aclk,
    input  logic                  axi_resetn,
    nf10_axis_downsizer_if.slave  s_axis,
    nf10_axis_downsizer_if.master m_axis
);

    localparam int N_LANES = C_S_AXIS_DATA_WIDTH / C_M_AXIS_DATA_WIDTH;
    localparam int CNT_W   = $clog2(N_LANES);
    localparam int SB      = C_S_AXIS_DATA_WIDTH / 8;
    localparam int MB      = C_M_AXIS_DATA_WIDTH / 8;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [CNT_W-1:0]                last_lane_q, last_lane_d;
    logic                            first_q, first_d;
    logic [C_S_AXIS_DATA_WIDTH-1:0]  data_q, data_d;
    logic [SB-1:0]                   strb_q, strb_d;
    logic                            tlast_q, tlast_d;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] pkt_user_q, pkt_user_d;

    logic [C_M_AXIS_DATA_WIDTH-1:0]  m_data_q, m_data_d;
    logic [MB-1:0]                   m_strb_q, m_strb_d;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] m_user_q, m_user_d;
    logic                            m_valid_q, m_valid_d;
    logic                            m_last_q, m_last_d;

    logic [CNT_W-1:0] found_lane;
    logic [CNT_W-1:0] new_last_lane;
    logic             m_hs;
    logic             s_hs;
    logic             beat_done;
    logic             s_ready;

    nf10_axis_last_lane_finder #(
        .STRB_W  (SB),
        .GROUP_W (MB),
        .OUT_W   (CNT_W)
    ) u_finder (
        .strb      (s_axis.tstrb),
        .last_lane (found_lane)
    );

    // Only the packet's final beat may be trimmed; middle beats send every lane.
    assign new_last_lane = s_axis.tlast ? found_lane : CNT_W'(N_LANES - 1);

    assign m_hs      = m_valid_q & m_axis.tready;
    assign beat_done = (state_q == SEND) & (cnt_q == last_lane_q) & m_axis.tready;
    assign s_ready   = (state_q == EMPTY) | beat_done;
    assign s_hs      = s_axis.tvalid & s_ready;

    // Next-state and next-output computation. Master outputs are registered, so
    // the lane that will be presented next is selected here from either the
    // incoming slave beat (on capture) or the held beat (on lane advance).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_lane_d = last_lane_q;
        first_d     = first_q;
        data_d      = data_q;
        strb_d      = strb_q;
        tlast_d     = tlast_q;
        pkt_user_d  = pkt_user_q;
        m_data_d    = m_data_q;
        m_strb_d    = m_strb_q;
        m_user_d    = m_user_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;

        // The beat after a taken tlast starts a new packet.
        if (m_hs) begin
            first_d = m_last_q;
        end

        if (s_hs) begin
            state_d     = SEND;
            cnt_d       = '0;
            last_lane_d = new_last_lane;
            data_d      = s_axis.tdata;
            strb_d      = s_axis.tstrb;
            tlast_d     = s_axis.tlast;
            if (first_d) begin
                pkt_user_d = s_axis.tuser;
            end
            m_data_d  = s_axis.tdata[C_M_AXIS_DATA_WIDTH-1:0];
            m_strb_d  = s_axis.tstrb[MB-1:0];
            m_valid_d = 1'b1;
            m_last_d  = s_axis.tlast & (new_last_lane == '0);
        end else if (m_hs) begin
            if (cnt_q == last_lane_q) begin
                state_d   = EMPTY;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end else begin
                cnt_d    = cnt_q + 1'b1;
                m_data_d = data_q[int'(cnt_d)*C_M_AXIS_DATA_WIDTH +: C_M_AXIS_DATA_WIDTH];
                m_strb_d = strb_q[int'(cnt_d)*MB +: MB];
                m_last_d = tlast_q & (cnt_d == last_lane_q);
            end
        end

        if (s_hs || (m_hs && (cnt_q != last_lane_q))) begin
`ifdef NF10_DOWNSIZER_TUSER_HOLD_EN
            m_user_d = pkt_user_d;
`else
            m_user_d = first_d ? pkt_user_d : '0;
`endif
        end
    end

    // All state and registered outputs. Reset abandons any held beat outright.
    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            state_q     <= EMPTY;
            cnt_q       <= '0;
            last_lane_q <= '0;
            first_q     <= 1'b1;
            data_q      <= '0;
            strb_q      <= '0;
            tlast_q     <= 1'b0;
            pkt_user_q  <= '0;
            m_data_q    <= '0;
            m_strb_q    <= '0;
            m_user_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_lane_q <= last_lane_d;
            first_q     <= first_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
            tlast_q     <= tlast_d;
            pkt_user_q  <= pkt_user_d;
            m_data_q    <= m_data_d;
            m_strb_q    <= m_strb_d;
            m_user_q    <= m_user_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tstrb  = m_strb_q;
    assign m_axis.tuser  = m_user_q;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_last_q;

endmodule

// File: tb/tb_nf10_axis_downsizer.sv
// tb_nf10_axis_downsizer
//   Scoreboard bench for nf10_axis_downsizer. Packets are described by byte
//   length; the expected 64-bit stream is the packet's byte stream cut into
//   8-byte words, which is pushed into a queue as stimulus is queued. A driver
//   feeds slave beats, a monitor pops and compares every master handshake and
//   checks that outputs hold while stalled.
module tb_nf10_axis_downsizer;
    import nf10_axis_pkg::*;

`ifdef NF10_DOWNSIZER_TUSER_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    typedef struct {
        logic [255:0] data;
        logic [31:0]  strb;
        logic [127:0] user;
        logic         last;
    } s_beat_t;

    typedef struct {
        logic [63:0]  data;
        logic [7:0]   strb;
        logic [127:0] user;
        logic         last;
    } m_beat_t;

    logic axi_aclk = 1'b0;
    logic axi_resetn = 1'b0;

    always #5 axi_aclk = ~axi_aclk;

    nf10_axis_downsizer_if #(.DATA_W(256), .USER_W(128)) s_if ();
    nf10_axis_downsizer_if #(.DATA_W(64),  .USER_W(128)) m_if ();

    nf10_axis_downsizer dut (
        .axi_aclk   (axi_aclk),
        .axi_resetn (axi_resetn),
        .s_axis     (s_if),
        .m_axis     (m_if)
    );

    s_beat_t    drv_q[$];
    m_beat_t    exp_q[$];
    logic [7:0] last_pkt[$];

    int vectors_applied = 0;
    int miscompares     = 0;
    int ready_mode      = 1;
    bit gaps_enable     = 1'b0;

    function automatic logic [127:0] expUser(input bit first_of_pkt, input logic [127:0] user);
        return (first_of_pkt || HOLD_EN) ? user : 128'h0;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic checkValue(input string name, input logic [255:0] got, input logic [255:0] req);
        vectors_applied++;
        if (got !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    // Queue one packet of len bytes: slave beats for the driver, 8-byte words for the scoreboard.
    task automatic applyStimulus(input int len, input logic [127:0] user);
        int nsb;
        int nmb;
        s_beat_t sb;
        m_beat_t mb;
        nsb = (len + 31) / 32;
        nmb = (len + 7) / 8;
        last_pkt.delete();
        for (int i = 0; i < nsb * 32; i++) last_pkt.push_back(8'($urandom));
        for (int b = 0; b < nsb; b++) begin
            for (int j = 0; j < 32; j++) begin
                sb.data[j*8 +: 8] = last_pkt[b*32 + j];
                sb.strb[j]        = (b*32 + j < len);
            end
            sb.user = (b == 0) ? user : {$urandom, $urandom, $urandom, $urandom};
            sb.last = (b == nsb - 1);
            drv_q.push_back(sb);
        end
        for (int k = 0; k < nmb; k++) begin
            for (int j = 0; j < 8; j++) begin
                mb.data[j*8 +: 8] = last_pkt[k*8 + j];
                mb.strb[j]        = (k*8 + j < len);
            end
            mb.user = expUser(k == 0, user);
            mb.last = (k == nmb - 1);
            exp_q.push_back(mb);
        end
    endtask

    task automatic pushRaw(input logic [255:0] d, input logic [31:0] s, input logic [127:0] u, input logic l);
        s_beat_t sb;
        sb.data = d; sb.strb = s; sb.user = u; sb.last = l;
        drv_q.push_back(sb);
    endtask

    task automatic pushExp(input logic [63:0] d, input logic [7:0] s, input logic [127:0] u, input logic l);
        m_beat_t mb;
        mb.data = d; mb.strb = s; mb.user = u; mb.last = l;
        exp_q.push_back(mb);
    endtask

    task automatic checkOutput();
        m_beat_t e;
        vectors_applied++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_beat: got data=%h strb=%h last=%b, required no beat",
                     m_if.tdata, m_if.tstrb, m_if.tlast);
            return;
        end
        e = exp_q.pop_front();
        if (m_if.tdata !== e.data || m_if.tstrb !== e.strb || m_if.tuser !== e.user || m_if.tlast !== e.last) begin
            miscompares++;
            $display("[TB] FAIL beat: got data=%h strb=%h user=%h last=%b, required data=%h strb=%h user=%h last=%b",
                     m_if.tdata, m_if.tstrb, m_if.tuser, m_if.tlast, e.data, e.strb, e.user, e.last);
        end
    endtask

    task automatic waitDrain(input int limit);
        int w;
        w = 0;
        while ((drv_q.size() != 0 || exp_q.size() != 0) && w < limit) begin
            @(posedge axi_aclk);
            w++;
        end
        repeat (4) @(posedge axi_aclk);
        if (drv_q.size() != 0 || exp_q.size() != 0) begin
            vectors_applied++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
            exp_q.delete();
            drv_q.delete();
        end
    endtask

    // Master-side backpressure, applied after the driver's updates each cycle.
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge axi_aclk);
            #2;
            case (ready_mode)
                0:       m_if.tready = 1'b0;
                1:       m_if.tready = 1'b1;
                default: m_if.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Slave driver: presents queued beats and holds each until accepted.
    initial begin
        s_beat_t b;
        bit hs;
        int w;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tstrb  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        @(posedge axi_aclk);
        #1;
        forever begin
            if (drv_q.size() == 0) begin
                s_if.tvalid = 1'b0;
                @(posedge axi_aclk);
                #1;
            end else begin
                if (gaps_enable && $urandom_range(0, 3) == 0) begin
                    s_if.tvalid = 1'b0;
                    @(posedge axi_aclk);
                    #1;
                end
                b = drv_q.pop_front();
                s_if.tdata  = b.data;
                s_if.tstrb  = b.strb;
                s_if.tuser  = b.user;
                s_if.tlast  = b.last;
                s_if.tvalid = 1'b1;
                hs = 1'b0;
                w  = 0;
                while (!hs && w < 2000) begin
                    @(negedge axi_aclk);
                    hs = s_if.tready;
                    @(posedge axi_aclk);
                    #1;
                    w++;
                end
                s_if.tvalid = 1'b0;
                if (!hs) begin
                    vectors_applied++;
                    miscompares++;
                    $display("[TB] FAIL s_handshake_timeout: got tready=0 for %0d cycles, required 1", w);
                end
            end
        end
    end

    // Monitor: scoreboard compare on each master handshake, hold check while stalled.
    logic [63:0]  hold_data;
    logic [7:0]   hold_strb;
    logic [127:0] hold_user;
    logic         hold_last;
    bit           stalled = 1'b0;

    always @(negedge axi_aclk) begin
        if (!axi_resetn) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                vectors_applied++;
                if (m_if.tvalid !== 1'b1 || m_if.tdata !== hold_data || m_if.tstrb !== hold_strb ||
                    m_if.tuser !== hold_user || m_if.tlast !== hold_last) begin
                    miscompares++;
                    $display("[TB] FAIL stall_hold: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             m_if.tvalid, m_if.tdata, m_if.tlast, hold_data, hold_last);
                end
            end
            if (m_if.tvalid && m_if.tready) begin
                checkOutput();
                stalled = 1'b0;
            end else if (m_if.tvalid) begin
                hold_data = m_if.tdata;
                hold_strb = m_if.tstrb;
                hold_user = m_if.tuser;
                hold_last = m_if.tlast;
                stalled   = 1'b1;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        logic [255:0] d1;
        logic [255:0] d2;
        logic [127:0] u;
        logic [63:0]  lane2;
        int lens[2];
        int ends[$];
        int acc;
        int rem;
        int take;
        int w;
        bit exp_ready;

        // Reset values
        axi_resetn = 1'b0;
        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        checkValue("rst_m_tvalid", 256'(m_if.tvalid), 256'd0);
        checkValue("rst_m_tlast",  256'(m_if.tlast),  256'd0);
        checkValue("rst_m_tdata",  256'(m_if.tdata),  256'd0);
        checkValue("rst_m_tstrb",  256'(m_if.tstrb),  256'd0);
        checkValue("rst_m_tuser",  256'(m_if.tuser),  256'd0);
        checkValue("rst_s_tready", 256'(s_if.tready), 256'd1);
        @(posedge axi_aclk);
        #1;
        axi_resetn = 1'b1;

        // Full 32-byte beat with distinctive tuser
        ready_mode = 1;
        u = 128'h1111_2222_3333_4444_5555_6666_7777_ABCD;
        applyStimulus(32, u);
        waitDrain(200);

        // 12-byte beat: strobes FF then 0F
        u = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(12, u);
        waitDrain(200);

        // Last beat with no strobes at all: single lane-0 beat
        d1 = rand256();
        u  = {$urandom, $urandom, $urandom, $urandom};
        pushRaw(d1, 32'h0, u, 1'b1);
        pushExp(d1[63:0], 8'h00, expUser(1'b1, u), 1'b1);
        waitDrain(200);

        // Non-contiguous strobes pass through; highest nonzero group ends the beat
        d1 = rand256();
        u  = {$urandom, $urandom, $urandom, $urandom};
        pushRaw(d1, 32'h00FF_000F, u, 1'b1);
        pushExp(d1[63:0],    8'h0F, expUser(1'b1, u), 1'b0);
        pushExp(d1[127:64],  8'h00, expUser(1'b0, u), 1'b0);
        pushExp(d1[191:128], 8'hFF, expUser(1'b0, u), 1'b1);
        waitDrain(200);

        // Middle beat with zero strobes still emits all four lanes
        d1 = rand256();
        d2 = rand256();
        u  = {$urandom, $urandom, $urandom, $urandom};
        pushRaw(d1, 32'h0, u, 1'b0);
        pushRaw(d2, 32'h0000_00FF, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        for (int k = 0; k < 4; k++) pushExp(d1[k*64 +: 64], 8'h00, expUser(k == 0, u), 1'b0);
        pushExp(d2[63:0], 8'hFF, expUser(1'b0, u), 1'b1);
        waitDrain(200);

        // Back-to-back 3-beat and 1-beat packets: 13 contiguous master beats
        lens[0] = 96;
        lens[1] = 8;
        acc = 0;
        ends.delete();
        foreach (lens[p]) begin
            rem = lens[p];
            while (rem > 0) begin
                take = (rem > 32) ? 32 : rem;
                acc  = acc + (take + 7) / 8;
                ends.push_back(acc - 1);
                rem  = rem - take;
            end
        end
        applyStimulus(lens[0], {$urandom, $urandom, $urandom, $urandom});
        applyStimulus(lens[1], {$urandom, $urandom, $urandom, $urandom});
        w = 0;
        @(negedge axi_aclk);
        while (!m_if.tvalid && w < 20) begin
            @(negedge axi_aclk);
            w++;
        end
        for (int k = 0; k < acc; k++) begin
            exp_ready = 1'b0;
            foreach (ends[e]) if (ends[e] == k) exp_ready = 1'b1;
            checkValue($sformatf("b2b_valid_%0d", k),   256'(m_if.tvalid), 256'd1);
            checkValue($sformatf("b2b_s_ready_%0d", k), 256'(s_if.tready), 256'(exp_ready));
            @(negedge axi_aclk);
        end
        checkValue("b2b_idle_after", 256'(m_if.tvalid), 256'd0);
        waitDrain(200);

        // Reset while lane 2 of a held beat is on the bus
        applyStimulus(32, {$urandom, $urandom, $urandom, $urandom});
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        for (int j = 0; j < 8; j++) lane2[j*8 +: 8] = last_pkt[16 + j];
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(posedge axi_aclk);
            #1;
            w++;
        end
        ready_mode = 0;
        axi_resetn = 1'b0;
        @(negedge axi_aclk);
        checkValue("midrst_lane2_valid", 256'(m_if.tvalid), 256'd1);
        checkValue("midrst_lane2_data",  256'(m_if.tdata),  256'(lane2));
        @(posedge axi_aclk);
        @(negedge axi_aclk);
        checkValue("midrst_m_tvalid", 256'(m_if.tvalid), 256'd0);
        checkValue("midrst_m_tlast",  256'(m_if.tlast),  256'd0);
        checkValue("midrst_s_tready", 256'(s_if.tready), 256'd1);
        @(posedge axi_aclk);
        #1;
        axi_resetn = 1'b1;
        ready_mode = 1;
        applyStimulus(64, {$urandom, $urandom, $urandom, $urandom});
        waitDrain(200);

        // Random packets with 50% master backpressure and slave gaps
        ready_mode  = 2;
        gaps_enable = 1'b1;
        for (int p = 0; p < 100; p++) begin
            int len;
            len = $urandom_range(60, 1514);
            u = {$urandom, $urandom, $urandom, $urandom};
            u[TUSER_LEN_HI:TUSER_LEN_LO] = 16'(len);
            u[TUSER_SRC_HI:TUSER_SRC_LO] = 8'($urandom);
            u[TUSER_DST_HI:TUSER_DST_LO] = 8'($urandom);
            applyStimulus(len, u);
        end
        waitDrain(60000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
